// File: rtl/register_file_8x32_pkg.sv
// ---------------------------------------------------------------------------
// register_file_8x32_pkg
// Shared constants and helpers for the 8-entry register file and its
// read multiplexers.
//   DATA_W_DEFAULT : default register / data-port width in bits
//   NUM_REGS       : number of architectural registers
//   ADDR_W         : register index width
//   COUNT_W        : width of the written-register count (holds 0..NUM_REGS)
// ---------------------------------------------------------------------------
package register_file_8x32_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int NUM_REGS       = 8;
  localparam int ADDR_W         = 3;
  localparam int COUNT_W        = 4;

  typedef logic [NUM_REGS-1:0] validMap_t;
  typedef logic [COUNT_W-1:0]  wrCount_t;

  // Number of set bits in a valid map. COUNT_W is wide enough to hold
  // NUM_REGS, so a fully written map reads as 8 rather than wrapping.
  function automatic wrCount_t countValid(input validMap_t map);
    wrCount_t total;
    total = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      total = total + wrCount_t'(map[i]);
    end
    return total;
  endfunction

endpackage

// File: rtl/register_file_8x32_mux.sv
// ---------------------------------------------------------------------------
// _8_to_1_MUX
// Plain combinational 8-to-1 word selector, one instance per read port of
// the register file.
//   data_i : eight WIDTH-bit input words
//   sel_i  : 3-bit index of the word to pass through
//   data_o : selected word
// ---------------------------------------------------------------------------
import register_file_8x32_pkg::*;

module _8_to_1_MUX #(
  parameter int WIDTH = DATA_W_DEFAULT
) (
  input  logic [WIDTH-1:0]  data_i [NUM_REGS],
  input  logic [ADDR_W-1:0] sel_i,
  output logic [WIDTH-1:0]  data_o
);

  // Every 3-bit index maps to a real entry, so the output is never X as
  // long as the inputs are defined; the default arm only keeps the case
  // visibly complete.
  always_comb begin
    data_o = '0;
    case (sel_i)
      3'd0:    data_o = data_i[0];
      3'd1:    data_o = data_i[1];
      3'd2:    data_o = data_i[2];
      3'd3:    data_o = data_i[3];
      3'd4:    data_o = data_i[4];
      3'd5:    data_o = data_i[5];
      3'd6:    data_o = data_i[6];
      3'd7:    data_o = data_i[7];
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/register_file_8x32.sv
// ---------------------------------------------------------------------------
// register_file_8x32
// Eight-entry register file with one write port, two combinational read
// ports, optional write-to-read forwarding and a per-register "written"
// map with a population count.
//   clk       : single clock, all state changes on its rising edge
//   reset     : asynchronous active-high reset of all state
//   clr       : synchronous clear of registers and valid map, wins over we
//   we        : write enable
//   wr_addr   : write register index
//   wr_data   : write data
//   ra0, ra1  : read-port indices
//   rd0, rd1  : read-port data (zero latency from address)
//   valid_map : bit i set once register i has been written
//   wr_count  : number of set bits in valid_map (0..8)
// ---------------------------------------------------------------------------
import register_file_8x32_pkg::*;

module register_file_8x32 #(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter bit BYPASS = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                we,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [ADDR_W-1:0]   ra0,
  input  logic [ADDR_W-1:0]   ra1,
  output logic [DATA_W-1:0]   rd0,
  output logic [DATA_W-1:0]   rd1,
  output logic [NUM_REGS-1:0] valid_map,
  output logic [COUNT_W-1:0]  wr_count
);

  logic [DATA_W-1:0] regFile_q [NUM_REGS];
  logic [DATA_W-1:0] regFile_d [NUM_REGS];
  validMap_t         validMap_q;
  validMap_t         validMap_d;
  wrCount_t          wrCount_q;
  wrCount_t          wrCount_d;
  validMap_t         wrSel;
  logic [DATA_W-1:0] muxOut0;
  logic [DATA_W-1:0] muxOut1;
  logic              fwdOk;

  // One-hot write decode of wr_addr, qualified by we.
  always_comb begin
    wrSel = '0;
    if (we) begin
      wrSel[wr_addr] = 1'b1;
    end
  end

  // Next-state for registers and the valid map. clr wipes everything and
  // ignores any write in the same cycle. Re-writing an already valid
  // register sets a bit that is already set, so the map and count stay put.
  always_comb begin
    regFile_d  = regFile_q;
    validMap_d = validMap_q;
    if (clr) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regFile_d[i] = '0;
      end
      validMap_d = '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wrSel[i]) begin
          regFile_d[i]  = wr_data;
          validMap_d[i] = 1'b1;
        end
      end
    end
    wrCount_d = countValid(validMap_d);
  end

  // State registers; reset clears immediately without waiting for clk,
  // which also discards whatever write was pending in that cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regFile_q[i] <= '0;
      end
      validMap_q <= '0;
      wrCount_q  <= '0;
    end else begin
      regFile_q  <= regFile_d;
      validMap_q <= validMap_d;
      wrCount_q  <= wrCount_d;
    end
  end

  assign valid_map = validMap_q;
  assign wr_count  = wrCount_q;

  _8_to_1_MUX #(
    .WIDTH (DATA_W)
  ) u_readMux0 (
    .data_i (regFile_q),
    .sel_i  (ra0),
    .data_o (muxOut0)
  );

  _8_to_1_MUX #(
    .WIDTH (DATA_W)
  ) u_readMux1 (
    .data_i (regFile_q),
    .sel_i  (ra1),
    .data_o (muxOut1)
  );

  // Forwarding only applies to a write that will actually land on the next
  // edge: not while clr discards it and not while reset is held.
  assign fwdOk = BYPASS && we && !clr && !reset;

  // Bypass sits after the muxes; reset forces both ports to zero.
  always_comb begin
    rd0 = muxOut0;
    rd1 = muxOut1;
    if (reset) begin
      rd0 = '0;
      rd1 = '0;
    end else begin
      if (fwdOk && (ra0 == wr_addr)) begin
        rd0 = wr_data;
      end
      if (fwdOk && (ra1 == wr_addr)) begin
        rd1 = wr_data;
      end
    end
  end

endmodule

// File: tb/tb_register_file_8x32.sv
// ---------------------------------------------------------------------------
// tb_register_file_8x32
// Drives one forwarding and one non-forwarding register file from the same
// inputs and compares their outputs against a small behavioural model.
// ---------------------------------------------------------------------------
module tb_register_file_8x32;

  localparam int W = 32;

  localparam int SEL_RD0B   = 0;
  localparam int SEL_RD1B   = 1;
  localparam int SEL_RD0N   = 2;
  localparam int SEL_RD1N   = 3;
  localparam int SEL_VALIDB = 4;
  localparam int SEL_COUNTB = 5;
  localparam int SEL_VALIDN = 6;
  localparam int SEL_COUNTN = 7;

  typedef struct {
    string          tag;
    int             sel;
    logic [W-1:0]   value;
  } expEntry_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         clr;
  logic         we;
  logic [2:0]   wrAddr;
  logic [W-1:0] wrData;
  logic [2:0]   ra0;
  logic [2:0]   ra1;

  logic [W-1:0] rd0B, rd1B, rd0N, rd1N;
  logic [7:0]   validB, validN;
  logic [3:0]   countB, countN;

  logic [W-1:0] modelRegs [8];
  logic [7:0]   modelValid;

  expEntry_t    scoreQ [$];
  int           compareCount = 0;
  int           failCount    = 0;

  register_file_8x32 #(.DATA_W(W), .BYPASS(1'b1)) dutBypass (
    .clk(clk), .reset(reset), .clr(clr), .we(we),
    .wr_addr(wrAddr), .wr_data(wrData), .ra0(ra0), .ra1(ra1),
    .rd0(rd0B), .rd1(rd1B), .valid_map(validB), .wr_count(countB)
  );

  register_file_8x32 #(.DATA_W(W), .BYPASS(1'b0)) dutNoBypass (
    .clk(clk), .reset(reset), .clr(clr), .we(we),
    .wr_addr(wrAddr), .wr_data(wrData), .ra0(ra0), .ra1(ra1),
    .rd0(rd0N), .rd1(rd1N), .valid_map(validN), .wr_count(countN)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] modelCount();
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      if (modelValid[i]) n = n + 4'd1;
    end
    return n;
  endfunction

  function automatic logic [W-1:0] modelRead(input logic fwd, input logic [2:0] addr);
    if (reset) return '0;
    if (fwd && we && !clr && (addr == wrAddr)) return wrData;
    return modelRegs[addr];
  endfunction

  function automatic logic [W-1:0] observe(input int sel);
    case (sel)
      SEL_RD0B:   return rd0B;
      SEL_RD1B:   return rd1B;
      SEL_RD0N:   return rd0N;
      SEL_RD1N:   return rd1N;
      SEL_VALIDB: return {24'b0, validB};
      SEL_COUNTB: return {28'b0, countB};
      SEL_VALIDN: return {24'b0, validN};
      SEL_COUNTN: return {28'b0, countN};
      default:    return 'x;
    endcase
  endfunction

  task automatic modelClear();
    for (int i = 0; i < 8; i++) modelRegs[i] = '0;
    modelValid = '0;
  endtask

  task automatic pushExp(input string tag, input int sel, input logic [W-1:0] value);
    expEntry_t e;
    e.tag   = tag;
    e.sel   = sel;
    e.value = value;
    scoreQ.push_back(e);
  endtask

  task automatic pushModel(input string tag);
    pushExp({tag, ".rd0B"},   SEL_RD0B,   modelRead(1'b1, ra0));
    pushExp({tag, ".rd1B"},   SEL_RD1B,   modelRead(1'b1, ra1));
    pushExp({tag, ".rd0N"},   SEL_RD0N,   modelRead(1'b0, ra0));
    pushExp({tag, ".rd1N"},   SEL_RD1N,   modelRead(1'b0, ra1));
    pushExp({tag, ".validB"}, SEL_VALIDB, {24'b0, modelValid});
    pushExp({tag, ".countB"}, SEL_COUNTB, {28'b0, modelCount()});
    pushExp({tag, ".validN"}, SEL_VALIDN, {24'b0, modelValid});
    pushExp({tag, ".countN"}, SEL_COUNTN, {28'b0, modelCount()});
  endtask

  task automatic applyStimulus(input logic w, input logic [2:0] wa, input logic [W-1:0] wd,
                               input logic [2:0] r0, input logic [2:0] r1, input logic c);
    we     = w;
    wrAddr = wa;
    wrData = wd;
    ra0    = r0;
    ra1    = r1;
    clr    = c;
  endtask

  task automatic checkOutput();
    expEntry_t    e;
    logic [W-1:0] obs;
    while (scoreQ.size() > 0) begin
      e   = scoreQ.pop_front();
      obs = observe(e.sel);
      compareCount++;
      assert (obs === e.value) else begin
        failCount++;
        $error("[TB] FAIL %s: observed %h, expected %h", e.tag, obs, e.value);
      end
    end
  endtask

  task automatic sampleCheck();
    @(negedge clk);
    checkOutput();
  endtask

  // Advance one rising edge, updating the model from the inputs seen there.
  task automatic clockEdge();
    @(posedge clk);
    if (reset || clr) begin
      modelClear();
    end else if (we) begin
      modelRegs[wrAddr]  = wrData;
      modelValid[wrAddr] = 1'b1;
    end
    #1;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 3'd0, '0, 3'd0, 3'd0, 1'b0);
    modelClear();
    clockEdge();
    clockEdge();

    // Write attempted while reset is held: no forwarding, reads stay zero.
    applyStimulus(1'b1, 3'd0, 32'hAAAA5555, 3'd0, 3'd0, 1'b0);
    pushExp("inReset.noForward", SEL_RD0B, '0);
    pushModel("inReset");
    sampleCheck();
    clockEdge();

    reset = 1'b0;
    applyStimulus(1'b0, 3'd0, '0, 3'd0, 3'd7, 1'b0);
    pushExp("afterReset.valid", SEL_VALIDB, 32'h0);
    pushExp("afterReset.count", SEL_COUNTB, 32'h0);
    pushModel("afterReset");
    sampleCheck();
    clockEdge();

    // Every address reads a defined zero.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 3'd0, '0, i[2:0], 3'(7 - i), 1'b0);
      #1;
      pushModel($sformatf("noX%0d", i));
      checkOutput();
    end
    clockEdge();

    // Write then read reg5.
    applyStimulus(1'b1, 3'd5, 32'hDEADBEEF, 3'd5, 3'd0, 1'b0);
    pushExp("wr5.fwdSameCycle", SEL_RD0B, 32'hDEADBEEF);
    pushExp("wr5.noFwdOld",     SEL_RD0N, 32'h0);
    pushModel("wr5.during");
    sampleCheck();
    clockEdge();
    applyStimulus(1'b0, 3'd0, '0, 3'd5, 3'd0, 1'b0);
    pushExp("wr5.rd0N",  SEL_RD0N,   32'hDEADBEEF);
    pushExp("wr5.valid", SEL_VALIDB, 32'h20);
    pushExp("wr5.count", SEL_COUNTB, 32'h1);
    pushModel("wr5.after");
    sampleCheck();
    clockEdge();

    // Forwarding on read port 1.
    applyStimulus(1'b1, 3'd3, 32'h12345678, 3'd0, 3'd3, 1'b0);
    pushExp("byp3.fwd",   SEL_RD1B, 32'h12345678);
    pushExp("byp3.noFwd", SEL_RD1N, 32'h0);
    pushModel("byp3.during");
    sampleCheck();
    clockEdge();
    applyStimulus(1'b0, 3'd0, '0, 3'd5, 3'd3, 1'b0);
    pushExp("byp3.rd1N",  SEL_RD1N,   32'h12345678);
    pushExp("byp3.valid", SEL_VALIDB, 32'h28);
    pushExp("byp3.count", SEL_COUNTN, 32'h2);
    pushModel("byp3.after");
    sampleCheck();
    clockEdge();

    // Fill every register with i * 0x11111111.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, i[2:0], W'(i) * 32'h11111111, i[2:0], 3'd0, 1'b0);
      pushModel($sformatf("fill%0d", i));
      sampleCheck();
      clockEdge();
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 3'd0, '0, i[2:0], 3'(7 - i), 1'b0);
      pushExp($sformatf("readBack%0d", i), SEL_RD0N, W'(i) * 32'h11111111);
      pushModel($sformatf("readBack%0d", i));
      sampleCheck();
      clockEdge();
    end

    // Rewrite reg2 with both ports reading it during the write.
    applyStimulus(1'b1, 3'd2, 32'hCAFEF00D, 3'd2, 3'd2, 1'b0);
    pushExp("rewrite.rd0B",  SEL_RD0B,   32'hCAFEF00D);
    pushExp("rewrite.rd1B",  SEL_RD1B,   32'hCAFEF00D);
    pushExp("rewrite.rd0N",  SEL_RD0N,   32'h22222222);
    pushExp("rewrite.valid", SEL_VALIDB, 32'hFF);
    pushExp("rewrite.count", SEL_COUNTB, 32'h8);
    sampleCheck();
    clockEdge();
    applyStimulus(1'b0, 3'd0, '0, 3'd2, 3'd2, 1'b0);
    pushExp("rewrite.newVal", SEL_RD1N,   32'hCAFEF00D);
    pushExp("rewrite.validN", SEL_VALIDN, 32'hFF);
    pushExp("rewrite.countN", SEL_COUNTN, 32'h8);
    pushModel("rewrite.after");
    sampleCheck();
    clockEdge();

    // clr together with a write to reg4: clear wins, no forwarding.
    applyStimulus(1'b1, 3'd4, 32'h0BADBAD0, 3'd4, 3'd4, 1'b1);
    pushExp("clr.noFwd", SEL_RD0B, 32'h44444444);
    pushModel("clr.during");
    sampleCheck();
    clockEdge();
    applyStimulus(1'b0, 3'd0, '0, 3'd4, 3'd7, 1'b0);
    pushExp("clr.reg4",  SEL_RD0B,   32'h0);
    pushExp("clr.reg7",  SEL_RD1N,   32'h0);
    pushExp("clr.valid", SEL_VALIDB, 32'h0);
    pushExp("clr.count", SEL_COUNTB, 32'h0);
    pushModel("clr.after");
    sampleCheck();
    clockEdge();

    // Asynchronous reset pulse between edges while a write is pending.
    applyStimulus(1'b1, 3'd1, 32'h01010101, 3'd1, 3'd1, 1'b0);
    pushModel("pre.wr1");
    sampleCheck();
    clockEdge();
    applyStimulus(1'b1, 3'd6, 32'h66666666, 3'd1, 3'd6, 1'b0);
    #1;
    reset = 1'b1;
    modelClear();
    #1;
    pushExp("async.reg1",  SEL_RD0B,   32'h0);
    pushExp("async.fwd6",  SEL_RD1B,   32'h0);
    pushExp("async.valid", SEL_VALIDB, 32'h0);
    pushModel("async.during");
    checkOutput();
    #1;
    reset = 1'b0;
    we    = 1'b0;
    pushModel("async.released");
    sampleCheck();
    clockEdge();
    applyStimulus(1'b0, 3'd0, '0, 3'd1, 3'd6, 1'b0);
    pushExp("async.lost6", SEL_RD1N,   32'h0);
    pushExp("async.count", SEL_COUNTB, 32'h0);
    pushModel("async.after");
    sampleCheck();
    clockEdge();

    // First write after reset lands on the next edge.
    applyStimulus(1'b1, 3'd6, 32'h66666666, 3'd6, 3'd6, 1'b0);
    pushModel("post.wr6");
    sampleCheck();
    clockEdge();
    applyStimulus(1'b0, 3'd0, '0, 3'd6, 3'd1, 1'b0);
    pushExp("post.rd0N",  SEL_RD0N,   32'h66666666);
    pushExp("post.valid", SEL_VALIDB, 32'h40);
    pushExp("post.count", SEL_COUNTB, 32'h1);
    pushModel("post.after");
    sampleCheck();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/register_file_8x32.md
REGISTER_FILE_8X32 -- requirements
Module: register_file_8x32

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, which sets the register and data-port width in bits.
REQ-002 The block SHALL have parameter BYPASS, default 1, which enables write-to-read forwarding when set to 1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port clr, input, 1 bit: synchronous clear of all registers and valid bits.
REQ-006 The block SHALL have port we, input, 1 bit: write enable.
REQ-007 The block SHALL have port wr_addr, input, 3 bits: write register index.
REQ-008 The block SHALL have port wr_data, input, DATA_W bits: write data.
REQ-009 The block SHALL have port ra0, input, 3 bits: read-port-0 register index.
REQ-010 The block SHALL have port ra1, input, 3 bits: read-port-1 register index.
REQ-011 The block SHALL have port rd0, output, DATA_W bits: read-port-0 data.
REQ-012 The block SHALL have port rd1, output, DATA_W bits: read-port-1 data.
REQ-013 The block SHALL have port valid_map, output, 8 bits: bit i is 1 once register i has been written since the last reset or clr.
REQ-014 The block SHALL have port wr_count, output, 4 bits: the number of set bits in valid_map (0..8).

Function
REQ-015 The block SHALL hold eight DATA_W-bit registers, reg0..reg7.
REQ-016 On a rising clk edge with clr=0 and we=1, the block SHALL load reg[wr_addr] with wr_data and set valid_map[wr_addr].
REQ-017 On a rising clk edge with clr=1, the block SHALL zero all registers and valid_map, whatever the value of we; clr has priority over we.
REQ-018 When we=0 and clr=0, the block SHALL hold all registers and valid_map unchanged.
REQ-019 The block SHALL select rd0 and rd1 combinationally from the registers by ra0 and ra1, with zero cycles of latency from address to data.
REQ-020 When BYPASS=1, we=1, clr=0 and ra0 equals wr_addr, the block SHALL drive rd0 with wr_data in that same cycle; rd1 SHALL behave the same way with ra1.
REQ-021 When BYPASS=0, read ports SHALL return the registered value only; a write becomes visible on the cycle after the clk edge.
REQ-022 A rewrite of a register that is already valid SHALL leave valid_map and wr_count unchanged.
REQ-023 The block SHALL update wr_count on the same edge as valid_map; wr_count SHALL saturate naturally at 8 and never wrap.
REQ-024 The block SHALL allow both read ports to address the same register, including the register being written, with no conflict.
REQ-025 The block SHALL NOT produce an X value on rd0 or rd1 for any 3-bit address.

Reset
REQ-026 While reset=1, the block SHALL force all registers to 0, valid_map to 8'h00 and wr_count to 0, independent of clk.
REQ-027 When reset asserts in the middle of a write, the block SHALL discard that write; the first write after reset deasserts SHALL take effect on the next rising clk edge.
REQ-028 While reset=1, rd0 and rd1 SHALL read 0, with the bypass path also disabled.

Structure
REQ-029 DATA_W default, NUM_REGS=8 and ADDR_W=3 SHALL live in the shared register-file package.
REQ-030 Read selection SHALL use two instances of the team's 32-bit 8-to-1 mux sub-module _8_to_1_MUX, one per read port, with the bypass logic placed after the mux.
REQ-031 The write decode (3-to-8 enable) and the valid_map/wr_count logic SHALL stay inline within the block.

Verification
REQ-032 The bench SHALL cover reset: assert reset, then release it -> rd0=rd1=0, valid_map=8'h00, wr_count=0.
REQ-033 The bench SHALL cover write then read: write 32'hDEADBEEF to reg5, with ra0=5 on the next cycle -> rd0=32'hDEADBEEF, valid_map=8'h20, wr_count=1.
REQ-034 The bench SHALL cover bypass: BYPASS=1, we=1, wr_addr=3, wr_data=32'h12345678, ra1=3 -> rd1=32'h12345678 in the same cycle; with BYPASS=0, rd1 reads the old value (0) until after the edge.
REQ-035 The bench SHALL cover the full map and a rewrite: write regs 0..7 with values i*0x11111111, then rewrite reg2 -> valid_map=8'hFF, wr_count=8 unchanged, and reg2 holds the new value.
REQ-036 The bench SHALL cover clr priority: clr=1 and we=1 to reg4 together -> all registers 0, valid_map=8'h00, and reg4 not written.
REQ-037 The bench SHALL cover asynchronous reset mid-operation: pulse reset between clk edges while we=1 -> the registers clear immediately, and the pending write is lost.
